ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Companion decoder/checker for the one-hot ring counter. Samples the counter's one-hot output `q` and the enable that drives that counter.
- Produces a binary position index, a lap counter and lap pulse, and a sticky fault flag whenever the observed sequence is not a legal rotation.
- Sits beside any ring counter instance: as a functional decoder in datapaths and as an in-system integrity monitor.

Parameters:
- N, 4: ring width in bits; legal range 2..32.
- IW, 2: index width; must satisfy 2^IW >= N.
- LW, 8: lap counter width.

Ports:
- clk  input  1  rising-edge clock, shared with the monitored ring counter.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  the same enable driving the ring counter, sampled on the same edge.
- q  input  N  ring counter output, bit 0 = position 0.
- resync  input  1  synchronous pulse; clears fault and returns to ACQUIRE.
- valid  output  1  idx, lap and lap_count reflect a tracked legal state.
- idx  output  IW  binary position of the set bit of q from the previous sample.
- lap  output  1  one-cycle pulse on each wrap from position N-1 to position 0.
- lap_count  output  LW  number of completed wraps since lock; modulo 2^LW.
- fault  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): state=ACQUIRE, valid=0, idx=0, lap=0, lap_count=0, fault=0, expected-next register=0. Release is sampled at the next rising edge.
- All outputs are registered. Every output reflects the q/en sampled at the preceding rising edge, i.e. 1 cycle of latency.
- onehot(q) is true iff exactly one bit of q is set. rotl(x) = {x[N-2:0], x[N-1]}.
- On every edge, the expected-next register loads `en ? rotl(q) : q`.
- ACQUIRE:
  - onehot(q): go to TRACK; valid=1; idx=position of q. lap stays 0, even if this first step wraps.
  - Otherwise (including q=0): stay in ACQUIRE; valid=0; fault stays 0.
- TRACK:
  - q == expected-next: stay; idx=position of q.
  - The step is a wrap (previous q had bit N-1 set, en was 1, current q has bit 0 set): lap=1 for one cycle and lap_count increments, wrapping from 2^LW-1 to 0.
  - q != expected-next (illegal value, skipped position, move while en=0, or stall while en=1): go to FAULT; fault=1; valid=0; lap=0.
- FAULT:
  - fault stays 1 and valid stays 0 regardless of q or en.
  - idx and lap_count hold their last TRACK values.
  - Exits only via resync or reset.
- resync=1 in any state, on an edge: next state ACQUIRE; fault=0; valid=0; lap=0; lap_count=0. The q sampled on that same edge is ignored. resync takes priority over every other transition.
- en=0 with a legal held q: no index change, no lap pulse.
- N=2: each enabled step from position 1 to position 0 is a lap.
- Reset asserted mid-run clears everything immediately, including a pending lap pulse.
- Width rules:
  - idx is zero-extended into IW bits.
  - lap_count uses unsigned modulo arithmetic.
  - No combinational path from any input to any output.

Test Plan:
- Reset held low, then released with q=4'b0001, en=1, and q rotating each cycle → valid=1 one edge after the first sample. idx sequence 0,1,2,3,0; lap pulses once on the 3→0 step; lap_count=1.
- 10 full rotations with en=1 and LW=3 → lap_count goes 1..7 then 0,1,2. Exactly 10 lap pulses, each one cycle wide.
- en=0 for 5 cycles with q held at 4'b0100 → idx stays 2, no lap, fault=0. Re-enable → idx goes 3, then 0 with lap=1.
- In TRACK, force q=4'b0110 (two bits set) → next edge fault=1, valid=0. Fault persists through 20 legal cycles. Pulse resync → fault=0, state returns to ACQUIRE, and the next legal sample brings valid=1 with lap_count=0.
- Skip fault: q goes 0001→0100 with en=1 → fault=1. Stall fault: q holds 0010 with en=1 → fault=1. Move fault: q goes 0010→0100 with en=0 → fault=1.
- Assert reset (low) asynchronously mid-cycle during TRACK at idx=3 → valid, idx, lap, lap_count and fault go to 0 without waiting for a clock edge. ACQUIRE resumes after release.

Source files
------------

// File: rtl/ring_decoder.sv
// Decoder and integrity checker for a one-hot ring counter: reports the
// position of the set bit, counts completed laps and latches a sticky fault
// whenever the observed sequence is not a legal rotation.
module ring_decoder #(
  parameter int N  = 4,
  parameter int IW = 2,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  q,
  input  logic          resync,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic          lap,
  output logic [LW-1:0] lap_count,
  output logic          fault
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [N-1:0]  exp_next;
  logic          wrap_arm;
  logic          q_onehot;
  logic [IW-1:0] q_pos;
  logic          valid_d, lap_d, fault_d;
  logic [IW-1:0] idx_d;
  logic [LW-1:0] lap_count_d;

  // Classify the current sample: is it one-hot, and where is its lowest set bit
  always_comb begin
    q_onehot = (q != '0) && ((q & (q - N'(1))) == '0);
    q_pos    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (q[i]) q_pos = IW'(i);
    end
  end

  // Next state and next output values; outputs hold unless a rule changes them
  always_comb begin
    state_d     = state;
    valid_d     = valid;
    idx_d       = idx;
    lap_d       = 1'b0;
    lap_count_d = lap_count;
    fault_d     = fault;
    if (resync) begin
      state_d     = ACQUIRE;
      valid_d     = 1'b0;
      lap_count_d = '0;
      fault_d     = 1'b0;
    end else begin
      case (state)
        ACQUIRE: begin
          if (q_onehot) begin
            state_d = TRACK;
            valid_d = 1'b1;
            idx_d   = q_pos;
          end else begin
            valid_d = 1'b0;
          end
        end
        TRACK: begin
          if (q == exp_next) begin
            idx_d = q_pos;
            if (wrap_arm && q[0]) begin
              lap_d       = 1'b1;
              lap_count_d = lap_count + LW'(1);
            end
          end else begin
            state_d = FAULT;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end
        end
        FAULT: begin
          valid_d = 1'b0;
          fault_d = 1'b1;
        end
        default: begin
          state_d = ACQUIRE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, output and prediction registers; wrap_arm remembers an enabled step out of position N-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACQUIRE;
      valid     <= 1'b0;
      idx       <= '0;
      lap       <= 1'b0;
      lap_count <= '0;
      fault     <= 1'b0;
      exp_next  <= '0;
      wrap_arm  <= 1'b0;
    end else begin
      state     <= state_d;
      valid     <= valid_d;
      idx       <= idx_d;
      lap       <= lap_d;
      lap_count <= lap_count_d;
      fault     <= fault_d;
      exp_next  <= en ? {q[N-2:0], q[N-1]} : q;
      wrap_arm  <= en & q[N-1];
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder (N=4, LW=3) with a position-based reference model.
module tb_ring_decoder;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int LW = 3;

  logic          clk;
  logic          reset;
  logic          en;
  logic [N-1:0]  q;
  logic          resync;
  logic          valid;
  logic [IW-1:0] idx;
  logic          lap;
  logic [LW-1:0] lap_count;
  logic          fault;

  int checks = 0;
  int errors = 0;
  int lap_seen = 0;
  string cur_tag = "init";

  // reference model state, in terms of positions and modes rather than bit vectors
  int         m_mode = 0;     // 0 acquire, 1 track, 2 fault
  int         m_prev_pos = 0;
  int         m_prev_en = 0;
  logic       m_valid = 0;
  logic [1:0] m_idx = 0;
  logic       m_lap = 0;
  logic [2:0] m_lapcnt = 0;
  logic       m_fault = 0;

  logic [N-1:0] ring;

  ring_decoder #(.N(N), .IW(IW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .en(en), .q(q), .resync(resync),
    .valid(valid), .idx(idx), .lap(lap), .lap_count(lap_count), .fault(fault)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int posOf(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_valid = 0; m_idx = 0; m_lap = 0; m_lapcnt = 0; m_fault = 0;
  endtask

  // one sampled edge of the reference model
  task automatic modelEdge(input logic [N-1:0] qv, input logic env, input logic rs);
    int exp_pos;
    if (rs) begin
      m_mode = 0; m_valid = 0; m_lap = 0; m_lapcnt = 0; m_fault = 0;
    end else begin
      case (m_mode)
        0: begin
          m_lap = 0;
          if ($countones(qv) == 1) begin
            m_mode = 1; m_valid = 1; m_idx = 2'(posOf(qv));
          end else m_valid = 0;
        end
        1: begin
          exp_pos = (m_prev_pos + m_prev_en) % N;
          if (qv == N'(1 << exp_pos)) begin
            m_idx = 2'(exp_pos);
            m_lap = (m_prev_en == 1) && (m_prev_pos == N - 1);
            if (m_lap) m_lapcnt = 3'((int'(m_lapcnt) + 1) % 8);
          end else begin
            m_mode = 2; m_fault = 1; m_valid = 0; m_lap = 0;
          end
        end
        default: m_lap = 0;
      endcase
    end
    m_prev_pos = posOf(qv);
    m_prev_en  = env ? 1 : 0;
  endtask

  task automatic checkOutput();
    checks++;
    assert (valid === m_valid) else begin
      errors++; $error("FAIL %s valid: got %0b expected %0b", cur_tag, valid, m_valid);
    end
    checks++;
    assert (idx === m_idx) else begin
      errors++; $error("FAIL %s idx: got %0d expected %0d", cur_tag, idx, m_idx);
    end
    checks++;
    assert (lap === m_lap) else begin
      errors++; $error("FAIL %s lap: got %0b expected %0b", cur_tag, lap, m_lap);
    end
    checks++;
    assert (lap_count === m_lapcnt) else begin
      errors++; $error("FAIL %s lap_count: got %0d expected %0d", cur_tag, lap_count, m_lapcnt);
    end
    checks++;
    assert (fault === m_fault) else begin
      errors++; $error("FAIL %s fault: got %0b expected %0b", cur_tag, fault, m_fault);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] qv, input logic env, input logic rs);
    q = qv; en = env; resync = rs;
    @(posedge clk);
    modelEdge(qv, env, rs);
    #1;
    checkOutput();
    if (lap === 1'b1) lap_seen++;
  endtask

  // drive the current ring value and advance it like a real ring counter would
  task automatic ringStep(input logic env);
    applyStimulus(ring, env, 1'b0);
    if (env) ring = {ring[N-2:0], ring[N-1]};
  endtask

  initial begin
    reset = 0; en = 1; q = 4'b0001; resync = 0;
    ring = 4'b0001;

    // reset held low
    cur_tag = "reset";
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkOutput();
    @(negedge clk) reset = 1;

    // first rotation: idx 0,1,2,3,0 with one lap
    cur_tag = "first_rotation";
    repeat (5) ringStep(1'b1);

    // ten rotations with a 3-bit lap counter
    cur_tag = "ten_rotations";
    lap_seen = 0;
    repeat (40) ringStep(1'b1);
    checks++;
    assert (lap_seen == 10) else begin
      errors++; $error("FAIL ten_rotations lap_pulses: got %0d expected 10", lap_seen);
    end

    // hold at position 2 with en low, then resume
    cur_tag = "enable_hold";
    ringStep(1'b1);
    repeat (5) ringStep(1'b0);
    repeat (3) ringStep(1'b1);

    // two-bit value forces a fault that persists until resync
    cur_tag = "double_bit_fault";
    applyStimulus(4'b0110, 1'b1, 1'b0);
    repeat (20) ringStep(1'b1);
    cur_tag = "resync";
    applyStimulus(ring, 1'b1, 1'b1);
    ring = {ring[N-2:0], ring[N-1]};
    repeat (2) ringStep(1'b1);

    // skip, stall and move faults
    cur_tag = "skip_fault";
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    cur_tag = "stall_fault";
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    cur_tag = "move_fault";
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b1);

    // asynchronous reset mid-cycle while tracking at position 3
    cur_tag = "async_reset";
    ring = 4'b0001;
    repeat (4) ringStep(1'b1);
    #2 reset = 0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk) reset = 1;
    cur_tag = "after_reset";
    ring = 4'b0100;
    repeat (6) ringStep(1'b1);

    // randomized run: mostly legal rotation, occasional corruption and resync
    cur_tag = "random";
    for (int k = 0; k < 500; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) applyStimulus(N'($urandom), 1'b1, 1'b0);
      else if (r < 7) begin
        applyStimulus(ring, 1'($urandom), 1'b1);
        ring = 4'b0001 << $urandom_range(0, N - 1);
      end else ringStep(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
